// File: rtl/clk_enable_pkg.sv
// Shared definitions for the clock-enable synthesiser.
//   DEF_ACC_W    : default accumulator / increment width
//   inc_t        : increment word at the default width
//   inc_from_hz  : rounded increment for a target enable rate at a given
//                  reference rate, saturated to the largest representable value
//   INC_*        : increments for the standard rates at a 50 MHz reference
package clk_enable_pkg;

    localparam int DEF_ACC_W = 32;

    typedef logic [DEF_ACC_W-1:0] inc_t;

    // A rate equal to the reference would need 2^ACC_W, which does not fit.
    // It saturates to all-ones, so one cycle in 2^ACC_W is dropped.
    function automatic inc_t inc_from_hz(input real f_out, input real f_ref);
        real    scaled;
        longint v;
        longint v_max;
        scaled = f_out * (2.0 ** DEF_ACC_W) / f_ref;
        v      = longint'(scaled);
        v_max  = (longint'(1) <<< DEF_ACC_W) - 1;
        if (v > v_max) begin
            v = v_max;
        end
        if (v < 0) begin
            v = 0;
        end
        return inc_t'(v);
    endfunction

    localparam real  F_REF_50M       = 50.0e6;
    localparam inc_t INC_50M_AT_50M  = inc_from_hz(50.0e6, F_REF_50M);
    localparam inc_t INC_42M857_AT_50M = inc_from_hz(42.857142e6, F_REF_50M);
    localparam inc_t INC_4M_AT_50M   = inc_from_hz(4.0e6, F_REF_50M);

endpackage

// File: rtl/clk_enable_chan.sv
// One clock-enable channel: phase accumulator, active increment, shadow
// increment with pending flag, registered enable and update-acknowledge.
//   refclk   : system clock
//   rst_n    : asynchronous active-low reset
//   wr       : load wr_inc into the shadow and mark it pending
//   wr_inc   : new increment
//   align    : zero the accumulator, force-apply any pending update
//   ce       : enable pulse, one cycle after the accumulator wraps
//   ack      : pulse in the cycle the new increment becomes active
//   pending  : a shadow increment is waiting to be applied
module clk_enable_chan
    import clk_enable_pkg::*;
#(
    parameter int               ACC_W    = DEF_ACC_W,
    parameter logic [ACC_W-1:0] INC_INIT = '0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic             align,
    output logic             ce,
    output logic             ack,
    output logic             pending
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] shadow;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign carry = sum[ACC_W];

    // Swapping the increment only on a wrap keeps every period either wholly
    // old-rate or wholly new-rate. A zero increment never wraps, so it takes
    // the update straight away; align takes it unconditionally.
    assign apply = pending && (align || carry || (inc == '0));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            inc     <= INC_INIT;
            shadow  <= '0;
            pending <= 1'b0;
            ce      <= 1'b0;
            ack     <= 1'b0;
        end else begin
            acc <= align ? '0 : sum[ACC_W-1:0];
            ce  <= carry && !align;
            ack <= apply;
            if (apply) begin
                inc <= shadow;
            end
            // A write landing with an apply re-arms pending with the new value
            // while the old shadow goes live.
            if (wr) begin
                shadow  <= wr_inc;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_enable_synth.sv
// Multi-channel clock-enable synthesiser. Each channel emits single-cycle
// enables at inc/2^ACC_W of refclk; increments are reprogrammed glitch-free.
//   refclk  : system clock
//   rst_n   : asynchronous active-low reset
//   cfg_wr  : increment write strobe
//   cfg_ch  : target channel (values >= NUM_CH are ignored)
//   cfg_inc : new increment
//   align   : global phase-align strobe
//   ce      : per-channel enable pulses
//   cfg_ack : per-channel pulse when a written increment becomes active
//   locked  : rates stable for LOCK_CYCLES cycles and nothing pending
module clk_enable_synth
    import clk_enable_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      ACC_W       = DEF_ACC_W,
    parameter int                      CH_W        = 2,
    parameter logic [NUM_CH*ACC_W-1:0] INC_RESET   = '0,
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              align,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] cfg_ack,
    output logic              locked
);

    localparam int             LCW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

    logic              wr_valid;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] pending;
    logic [LCW-1:0]    lock_cnt;
    logic [LCW-1:0]    lock_cnt_next;
    logic              lock_clr;

    assign wr_valid = cfg_wr && (int'(cfg_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_valid && (int'(cfg_ch) == i);

        clk_enable_chan #(
            .ACC_W    (ACC_W),
            .INC_INIT (INC_RESET[i*ACC_W +: ACC_W])
        ) u_chan (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .wr      (wr_sel[i]),
            .wr_inc  (cfg_inc),
            .align   (align),
            .ce      (ce[i]),
            .ack     (cfg_ack[i]),
            .pending (pending[i])
        );
    end

    always_comb begin
        lock_clr = wr_valid || align || (|pending);
        if (lock_clr) begin
            lock_cnt_next = '0;
        end else if (lock_cnt == LOCK_MAX) begin
            lock_cnt_next = lock_cnt;
        end else begin
            lock_cnt_next = lock_cnt + 1'b1;
        end
    end

    // locked is registered from the next count so it tracks
    // (lock_cnt == LOCK_CYCLES) exactly and falls right after a clearing event.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next;
            locked   <= (lock_cnt_next == LOCK_MAX);
        end
    end

endmodule
